// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencing controller for the MIPS pipeline: program load,
// run/step control and an ordered PC/register/memory dump stream.
module pipeline_debug_ctrl #(
    parameter int INST_SZ        = 32,
    parameter int PC_SZ          = 32,
    parameter int REG_SZ         = 5,
    parameter int MEM_SZ         = 10,
    parameter int NUM_REGS       = 32,
    parameter int MEM_DUMP_DEPTH = 32,
    parameter int RD_LAT         = 1,
    parameter int MAX_RUN_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [1:0]         i_cmd,
    input  logic [INST_SZ-1:0] i_cmd_data,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_enable,
    output logic [MEM_SZ-1:0]  o_debug_addr,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_reg_data,
    input  logic [INST_SZ-1:0] i_mem_data,
    input  logic               i_halt,
    output logic [INST_SZ-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_tx_last,
    input  logic               i_tx_ready,
    output logic               o_done,
    output logic               o_timeout,
    output logic [MEM_SZ:0]    o_load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_DUMP_PC,
        S_DUMP_REG,
        S_DUMP_MEM,
        S_DUMP_WAIT
    } state_e;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    localparam logic [MEM_SZ:0]   LOAD_SAT  = {1'b1, {MEM_SZ{1'b0}}};
    localparam logic [MEM_SZ-1:0] REG_LAST  = MEM_SZ'(NUM_REGS - 1);
    localparam logic [MEM_SZ-1:0] MEM_LAST  = MEM_SZ'(MEM_DUMP_DEPTH - 1);
    localparam logic [MEM_SZ-1:0] REG_MASK  = MEM_SZ'((1 << REG_SZ) - 1);
    localparam logic [31:0]       RUN_MAX   = 32'(MAX_RUN_CYCLES);
    localparam logic [1:0]        WAIT_INIT =
        (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam bit                HAS_REGS  = (NUM_REGS > 0);
    localparam bit                HAS_MEM   = (MEM_DUMP_DEPTH > 0);

    state_e               state_q,    state_d;
    logic [INST_SZ-1:0]   instr_q,    instr_d;
    logic [MEM_SZ:0]      load_cnt_q, load_cnt_d;
    logic [31:0]          run_cnt_q,  run_cnt_d;
    logic                 timeout_q,  timeout_d;
    logic                 done_q,     done_d;
    logic [MEM_SZ-1:0]    addr_q,     addr_d;
    logic                 mem_sel_q,  mem_sel_d;
    logic [1:0]           wait_q,     wait_d;
    logic [INST_SZ-1:0]   tx_data_q,  tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 tx_last_q,  tx_last_d;

    logic                 nxt_word;
    logic                 nxt_mem;
    logic [MEM_SZ-1:0]    nxt_addr;
    logic                 fin;
    logic [INST_SZ-1:0]   pc_ext;

    always_comb begin
        pc_ext = '0;
        pc_ext[PC_SZ-1:0] = i_pc;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            load_cnt_q <= '0;
            run_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            mem_sel_q  <= 1'b0;
            wait_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            load_cnt_q <= load_cnt_d;
            run_cnt_q  <= run_cnt_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            mem_sel_q  <= mem_sel_d;
            wait_q     <= wait_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        load_cnt_d = load_cnt_q;
        run_cnt_d  = run_cnt_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        mem_sel_d  = mem_sel_q;
        wait_d     = wait_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        nxt_word   = 1'b0;
        nxt_mem    = 1'b0;
        nxt_addr   = '0;
        fin        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    timeout_d = 1'b0;
                    case (i_cmd)
                        CMD_LOAD: begin
                            state_d = S_LOAD;
                            instr_d = i_cmd_data;
                        end
                        CMD_RUN: begin
                            state_d   = S_RUN;
                            run_cnt_d = '0;
                        end
                        CMD_STEP: state_d = S_STEP;
                        CMD_DUMP: begin
                            state_d = S_DUMP_PC;
                            addr_d  = '0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                if (load_cnt_q != LOAD_SAT) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 32'd1;
                // Halt is checked first so it wins over a coincident budget hit.
                if (i_halt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (RUN_MAX != '0 && run_cnt_d == RUN_MAX) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_DUMP_PC: begin
                if (!tx_valid_q) begin
                    tx_data_d  = pc_ext;
                    tx_valid_d = 1'b1;
                    tx_last_d  = !HAS_REGS && !HAS_MEM;
                end else if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (tx_last_q) begin
                        fin = 1'b1;
                    end else begin
                        nxt_word = 1'b1;
                        nxt_mem  = !HAS_REGS;
                    end
                end
            end
            S_DUMP_REG: begin
                if (!tx_valid_q) begin
                    tx_data_d  = i_reg_data;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (addr_q == REG_LAST) && !HAS_MEM;
                end else if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (tx_last_q) begin
                        fin = 1'b1;
                    end else if (addr_q == REG_LAST) begin
                        nxt_word = 1'b1;
                        nxt_mem  = 1'b1;
                    end else begin
                        nxt_word = 1'b1;
                        nxt_addr = (addr_q + 1'b1) & REG_MASK;
                    end
                end
            end
            S_DUMP_MEM: begin
                if (!tx_valid_q) begin
                    tx_data_d  = i_mem_data;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (addr_q == MEM_LAST);
                end else if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (tx_last_q) begin
                        fin = 1'b1;
                    end else begin
                        nxt_word = 1'b1;
                        nxt_mem  = 1'b1;
                        nxt_addr = addr_q + 1'b1;
                    end
                end
            end
            S_DUMP_WAIT: begin
                if (wait_q == '0) begin
                    state_d = mem_sel_q ? S_DUMP_MEM : S_DUMP_REG;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
        endcase

        // New address goes out now; capture follows after RD_LAT cycles.
        if (nxt_word) begin
            addr_d    = nxt_addr;
            mem_sel_d = nxt_mem;
            if (RD_LAT == 0) begin
                state_d = nxt_mem ? S_DUMP_MEM : S_DUMP_REG;
            end else begin
                state_d = S_DUMP_WAIT;
                wait_d  = WAIT_INIT;
            end
        end

        if (fin) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            addr_d    = '0;
            mem_sel_d = 1'b0;
            tx_last_d = 1'b0;
        end
    end

    assign o_cmd_ready   = (state_q == S_IDLE);
    assign o_write       = (state_q == S_LOAD);
    assign o_enable      = (state_q == S_RUN) || (state_q == S_STEP);
    assign o_instruction = instr_q;
    assign o_debug_addr  = addr_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_tx_last     = tx_last_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_load_count  = load_cnt_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: load, run/halt, run budget,
// step, dump with back-pressure and reset mid-dump.
module tb_pipeline_debug_ctrl;

    localparam logic [1:0] C_LOAD = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_DUMP = 2'b11;

    logic        i_clk;
    logic        i_reset;
    logic [1:0]  i_cmd;
    logic [31:0] i_cmd_data;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        o_write;
    logic [31:0] o_instruction;
    logic        o_enable;
    logic [9:0]  o_debug_addr;
    logic [31:0] i_pc;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic        i_halt;
    logic [31:0] o_tx_data;
    logic        o_tx_valid;
    logic        o_tx_last;
    logic        i_tx_ready;
    logic        o_done;
    logic        o_timeout;
    logic [10:0] o_load_count;

    pipeline_debug_ctrl #(
        .INST_SZ       (32),
        .PC_SZ         (32),
        .REG_SZ        (5),
        .MEM_SZ        (10),
        .NUM_REGS      (4),
        .MEM_DUMP_DEPTH(4),
        .RD_LAT        (1),
        .MAX_RUN_CYCLES(16)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_cmd        (i_cmd),
        .i_cmd_data   (i_cmd_data),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .o_write      (o_write),
        .o_instruction(o_instruction),
        .o_enable     (o_enable),
        .o_debug_addr (o_debug_addr),
        .i_pc         (i_pc),
        .i_reg_data   (i_reg_data),
        .i_mem_data   (i_mem_data),
        .i_halt       (i_halt),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_tx_last    (o_tx_last),
        .i_tx_ready   (i_tx_ready),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_load_count (o_load_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int halt_mode = 0;
    int rdy_mode  = 0;

    int          wr_n   = 0;
    int          en_n   = 0;
    int          done_n = 0;
    int          rlow_n = 0;
    int          tx_n   = 0;
    int          stab_n = 0;
    logic        hold_q = 1'b0;
    logic [31:0] hold_data = '0;
    logic [31:0] wr_word  [0:15];
    logic [31:0] tx_word  [0:63];
    logic        tx_lastf [0:63];

    logic [31:0] load_vec [0:3] = '{
        32'h2002_0002, 32'hAC02_0002, 32'h0002_5021, 32'h0000_003F
    };
    logic [31:0] dump_exp [0:8] = '{
        32'h0, 32'h0, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 32'h2, 32'h0
    };

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Register file / data memory with one cycle of read latency.
    always @(posedge i_clk) begin
        i_reg_data <= (o_debug_addr == 10'd2) ? 32'd2 : 32'd0;
        i_mem_data <= (o_debug_addr == 10'd2) ? 32'd2 : 32'd0;
    end

    always @(negedge i_clk) begin
        if (o_write) begin
            if (wr_n < 16) wr_word[wr_n] <= o_instruction;
            wr_n <= wr_n + 1;
        end
        if (o_enable) en_n <= en_n + 1;
        if (o_done) done_n <= done_n + 1;
        if (!o_cmd_ready) rlow_n <= rlow_n + 1;
        if (o_tx_valid && i_tx_ready) begin
            if (tx_n < 64) begin
                tx_word[tx_n]  <= o_tx_data;
                tx_lastf[tx_n] <= o_tx_last;
            end
            tx_n <= tx_n + 1;
        end
        if (hold_q && (!o_tx_valid || o_tx_data != hold_data))
            stab_n <= stab_n + 1;
        hold_q    <= o_tx_valid && !i_tx_ready;
        hold_data <= o_tx_data;
    end

    // Pipeline halt model: raises HALT after its 9th enabled cycle.
    initial begin
        int run_en;
        run_en = 0;
        i_halt = 1'b0;
        forever begin
            @(negedge i_clk);
            if (halt_mode == 0) begin
                run_en = 0;
                i_halt = 1'b0;
            end else if (halt_mode == 2) begin
                i_halt = 1'b1;
            end else begin
                if (o_enable) run_en++;
                i_halt = (run_en >= 9);
            end
        end
    end

    initial begin
        int rc;
        rc = 0;
        i_tx_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            rc++;
            i_tx_ready = (rdy_mode == 0) ? 1'b1 : (rc % 3 == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [31:0] d);
        int n;
        n = 0;
        while (!o_cmd_ready && n < 50) begin
            idle(1);
            n++;
        end
        if (!o_cmd_ready) check("cmd_ready_wait", o_cmd_ready, 1'b1);
        i_cmd       = c;
        i_cmd_data  = d;
        i_cmd_valid = 1'b1;
        idle(1);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base,
                             input int budget);
        int n;
        n = 0;
        while (done_n == base && n < budget) begin
            idle(1);
            n++;
        end
        check({tag, "_done_seen"}, done_n != base, 1'b1);
    endtask

    task automatic run_dump(input logic [31:0] pc, input string tag);
        int b, d0, e0;
        logic [31:0] ew;
        i_pc = pc;
        idle(1);
        b  = tx_n;
        d0 = done_n;
        e0 = en_n;
        do_cmd(C_DUMP, 32'h0);
        wait_done(tag, d0, 400);
        idle(2);
        check({tag, "_words"}, tx_n - b, 9);
        for (int i = 0; i < 9; i++) begin
            ew = (i == 0) ? pc : dump_exp[i];
            check($sformatf("%s_w%0d", tag, i), tx_word[b+i], ew);
            check($sformatf("%s_last%0d", tag, i), tx_lastf[b+i], i == 8);
        end
        check({tag, "_done_pulses"}, done_n - d0, 1);
        check({tag, "_no_enable"}, en_n - e0, 0);
        check({tag, "_addr_idle"}, o_debug_addr, 0);
    endtask

    initial begin
        int w0, r0, d0, e0, b, n;
        i_reset     = 1'b1;
        i_cmd       = 2'b00;
        i_cmd_data  = '0;
        i_cmd_valid = 1'b0;
        i_pc        = '0;
        idle(3);
        check("rst_cmd_ready", o_cmd_ready, 1'b1);
        check("rst_write", o_write, 1'b0);
        check("rst_enable", o_enable, 1'b0);
        check("rst_tx_valid", o_tx_valid, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_load_count", o_load_count, 0);
        i_reset = 1'b0;
        idle(2);

        w0 = wr_n;
        r0 = rlow_n;
        for (int i = 0; i < 4; i++) do_cmd(C_LOAD, load_vec[i]);
        idle(3);
        check("load_writes", wr_n - w0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("load_word%0d", i), wr_word[w0+i], load_vec[i]);
        check("load_count", o_load_count, 4);
        check("load_busy_cycles", rlow_n - r0, 4);

        halt_mode = 1;
        d0 = done_n;
        e0 = en_n;
        do_cmd(C_RUN, 32'h0);
        wait_done("run_halt", d0, 100);
        idle(2);
        check("run_halt_enable", en_n - e0, 9);
        check("run_halt_done", done_n - d0, 1);
        check("run_halt_timeout", o_timeout, 1'b0);
        halt_mode = 0;
        idle(2);

        d0 = done_n;
        e0 = en_n;
        do_cmd(C_RUN, 32'h0);
        wait_done("run_budget", d0, 100);
        idle(2);
        check("run_budget_enable", en_n - e0, 16);
        check("run_budget_timeout", o_timeout, 1'b1);

        d0 = done_n;
        e0 = en_n;
        do_cmd(C_STEP, 32'h0);
        check("step_clears_timeout", o_timeout, 1'b0);
        wait_done("step", d0, 20);
        idle(2);
        check("step_enable", en_n - e0, 1);
        check("step_done", done_n - d0, 1);

        halt_mode = 2;
        idle(2);
        d0 = done_n;
        e0 = en_n;
        do_cmd(C_RUN, 32'h0);
        wait_done("run_prehalt", d0, 20);
        idle(2);
        check("run_prehalt_enable", en_n - e0, 1);
        check("run_prehalt_timeout", o_timeout, 1'b0);
        halt_mode = 0;
        idle(2);

        rdy_mode = 0;
        run_dump(32'h10, "dump_rdy");

        rdy_mode = 1;
        idle(1);
        b = stab_n;
        run_dump(32'h10, "dump_bp");
        check("dump_bp_stable", stab_n - b, 0);
        rdy_mode = 0;
        idle(2);

        i_pc = 32'h10;
        b  = tx_n;
        d0 = done_n;
        do_cmd(C_DUMP, 32'h0);
        n = 0;
        while (tx_n - b < 3 && n < 200) begin
            idle(1);
            n++;
        end
        check("mid_words_before_reset", tx_n - b, 3);
        check("mid_addr_before_reset", o_debug_addr, 2);
        i_reset = 1'b1;
        #1;
        check("mid_rst_cmd_ready", o_cmd_ready, 1'b1);
        check("mid_rst_tx_valid", o_tx_valid, 1'b0);
        check("mid_rst_addr", o_debug_addr, 0);
        check("mid_rst_load_count", o_load_count, 0);
        idle(2);
        i_reset = 1'b0;
        idle(3);
        check("mid_rst_no_done", done_n - d0, 0);
        run_dump(32'h24, "dump_after_rst");

        w0 = wr_n;
        for (int i = 0; i < 1030; i++) do_cmd(C_LOAD, i);
        idle(3);
        check("sat_writes", wr_n - w0, 1030);
        check("sat_load_count", o_load_count, 1024);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
Sequencing controller between a host command stream and the MIPS pipeline's debug port. It loads programs into instruction memory, runs the pipeline to HALT or a cycle budget, single-steps it, and dumps PC, registers and data memory as an ordered word stream. It replaces hand-sequenced write/enable/debug_addr stimulus and is the core a UART debug unit drives.

Parameters:
INST_SZ, 32, instruction/data word width
PC_SZ, 32, PC width (≤ INST_SZ)
REG_SZ, 5, register address width
MEM_SZ, 10, debug address width (≥ REG_SZ), shared by reg and mem reads
NUM_REGS, 32, registers dumped (≤ 2**REG_SZ)
MEM_DUMP_DEPTH, 32, data-memory words dumped (≤ 2**MEM_SZ)
RD_LAT, 1, cycles from o_debug_addr change to valid i_reg_data/i_mem_data (0..3)
MAX_RUN_CYCLES, 1024, RUN cycle budget; 0 = unlimited

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_cmd  in  2  00 LOAD, 01 RUN, 10 STEP, 11 DUMP
i_cmd_data  in  INST_SZ  instruction word for LOAD
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  high only in IDLE
o_write  out  1  instruction-memory write strobe to pipeline
o_instruction  out  INST_SZ  instruction to write
o_enable  out  1  pipeline run enable
o_debug_addr  out  MEM_SZ  reg/mem debug read address
i_pc  in  PC_SZ  pipeline PC
i_reg_data  in  INST_SZ  register debug read data
i_mem_data  in  INST_SZ  memory debug read data
i_halt  in  1  pipeline HALT flag (level)
o_tx_data  out  INST_SZ  dump word
o_tx_valid  out  1  dump word valid
o_tx_last  out  1  final dump word
i_tx_ready  in  1  downstream ready
o_done  out  1  one-cycle pulse on RUN/STEP/DUMP completion
o_timeout  out  1  RUN ended by budget; sticky until next accepted command
o_load_count  out  MEM_SZ+1  words loaded since reset

Behaviour:
- Reset: all outputs 0, except o_cmd_ready=1 (IDLE); o_load_count=0; state IDLE.
- Command accepted on edge with i_cmd_valid && o_cmd_ready; accepting clears o_timeout. Non-IDLE states ignore i_cmd_valid.
- States: IDLE, LOAD, RUN, STEP, DUMP_PC, DUMP_REG, DUMP_MEM, DUMP_WAIT (read latency).
- LOAD: next cycle o_write=1 for exactly one cycle, o_instruction=i_cmd_data latched at accept; o_load_count increments, saturating at 2**MEM_SZ (further LOADs still strobe). Back to IDLE; back-to-back LOADs give one word per 2 cycles.
- RUN: o_enable=1 from cycle after accept. If i_halt=1 on an edge, o_enable drops registered on that edge, o_done pulses, IDLE. If MAX_RUN_CYCLES≠0 and enable-cycle count reaches it without halt: same exit, o_timeout=1. Halt and budget on same edge: halt wins, o_timeout=0. RUN with i_halt already high: one enable cycle, then exit.
- STEP: o_enable=1 for exactly one cycle, then o_done, IDLE; i_halt ignored.
- DUMP: o_enable held 0. Order: word0={0-extended i_pc}; then regs 0..NUM_REGS-1; then mem 0..MEM_DUMP_DEPTH-1. Total 1+NUM_REGS+MEM_DUMP_DEPTH words.
- Per reg/mem word: drive o_debug_addr, wait RD_LAT cycles (DUMP_WAIT), capture into o_tx_data, assert o_tx_valid. Held stable until i_tx_ready; transfer on valid&&ready edge; then next address. RD_LAT=0: capture same cycle address set.
- o_tx_last=1 with final word only; after its transfer o_done pulses, IDLE, o_debug_addr returns 0.
- o_tx_valid never deasserts without a transfer (AXI-stream rule).
- Reset mid-operation: immediate return to reset values; partial dump abandoned; o_load_count cleared.

Test Plan:
- LOAD ADDI 0x20020002, SW 0xAC020002, ADDU 0x0002_5021, HALT 0x0000_003F -> four one-cycle o_write pulses with those words, o_load_count=4, o_cmd_ready low exactly one cycle per LOAD.
- RUN with i_halt modelled rising 9 cycles after o_enable -> o_enable high 9 cycles, o_done pulse, o_timeout=0.
- MAX_RUN_CYCLES=16, i_halt tied 0 -> o_enable high exactly 16 cycles, o_timeout=1; next STEP clears it and gives one enable cycle.
- DUMP, NUM_REGS=4, MEM_DUMP_DEPTH=4, RD_LAT=1, i_tx_ready always 1, reg model r2=2, mem[2]=2, i_pc=0x10 -> 9 words 0x10,0,0,2,0,0,0,2,0; o_tx_last on 9th only.
- Same DUMP with i_tx_ready toggling 1-of-3 cycles -> identical sequence, o_tx_data stable while valid&&!ready.
- i_reset asserted mid-DUMP at word 3 -> outputs zero that cycle (o_cmd_ready=1 after), no o_done; fresh DUMP restarts from PC word.
